// File: rtl/padd_pkg.sv
// ---------------------------------------------------------------------------
// padd_pkg -- shared types and defaults for the pipelined adder.
//
// Contents:
//   WIDTH_DEF / STAGES_DEF : default operand width and pipeline depth
//   PADD_MAX_W             : widest operand the stage payload can carry
//   padd_payload_t         : per-stage pipeline payload (valid, carry, the
//                            result chunks already computed, and the operand
//                            chunks still waiting to be added)
//   padd_flags_t           : result flags, used when PADD_FLAGS_EN is defined
// ---------------------------------------------------------------------------
package padd_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int STAGES_DEF = 4;

  // The payload is sized for the widest supported operand so that one type
  // serves every WIDTH. Bits above WIDTH stay zero and are trimmed away.
  localparam int PADD_MAX_W = 64;

  // The done and pending fields are shift registers. Each stage consumes the
  // low CHUNK bits of pend_a/pend_b and shifts its chunk sum in at the top of
  // done. After STAGES stages, done holds the full result in bit order.
  typedef struct packed {
    logic                  valid;
    logic                  carry;
    logic [PADD_MAX_W-1:0] done;
    logic [PADD_MAX_W-1:0] pend_a;
    logic [PADD_MAX_W-1:0] pend_b;
  } padd_payload_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
  } padd_flags_t;

endpackage : padd_pkg

// File: rtl/padd_stage.sv
// ---------------------------------------------------------------------------
// padd_stage -- one CHUNK-bit ripple slice of the pipelined adder, plus its
// pipeline register.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears the whole payload
//   en_i  : advance enable; the register holds its contents when low
//   p_i   : payload from the previous stage (or from input capture)
//   d_o   : next-state payload, present only when PADD_FLAGS_EN is defined,
//           so the top can register flags in step with the final stage
//   p_o   : registered payload handed to the next stage
//
// Configuration macro: PADD_FLAGS_EN
// ---------------------------------------------------------------------------
module padd_stage
  import padd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = WIDTH_DEF / STAGES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  padd_payload_t p_i,
`ifdef PADD_FLAGS_EN
  output padd_payload_t d_o,
`endif
  output padd_payload_t p_o
);

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_carry;
  logic [WIDTH-1:0] sum_w;
  padd_payload_t    p_d;
  padd_payload_t    p_q;

  // Plain ripple over this stage's chunk. This is the only combinational
  // carry path per stage.
  // NOTE: blocking assignments inside always_comb let the carry variable
  // ripple bit by bit within one evaluation; every output is assigned first
  // so no latch is inferred.
  always_comb begin
    logic c;
    c         = p_i.carry;
    chunk_sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_sum[i] = p_i.pend_a[i] ^ p_i.pend_b[i] ^ c;
      c = (p_i.pend_a[i] & p_i.pend_b[i]) | (c & (p_i.pend_a[i] ^ p_i.pend_b[i]));
    end
    chunk_carry = c;
  end

  // Shift the chunk sum in at the top of done, and drop the consumed chunk
  // from the pending operands. A full-width shift also covers CHUNK == WIDTH,
  // where there are no lower or upper chunks to carry along.
  always_comb begin
    sum_w                 = WIDTH'(chunk_sum);
    p_d                   = p_i;
    p_d.carry             = chunk_carry;
    p_d.done[WIDTH-1:0]   = (p_i.done[WIDTH-1:0] >> CHUNK) | (sum_w << (WIDTH - CHUNK));
    p_d.pend_a[WIDTH-1:0] = p_i.pend_a[WIDTH-1:0] >> CHUNK;
    p_d.pend_b[WIDTH-1:0] = p_i.pend_b[WIDTH-1:0] >> CHUNK;
  end

  // NOTE: the data fields are reset along with valid, so a flushed pipeline
  // presents sum=0/cout=0 and never exposes stale operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;
`ifdef PADD_FLAGS_EN
  assign d_o = p_d;
`endif

endmodule : padd_stage

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder -- WIDTH-bit add/subtract split into STAGES carry-chained
// CHUNK-bit slices, one pipeline register per slice, with a valid/ready
// handshake on both sides and a global stall.
//
// Ports:
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  : operand beat handshake
//   a, b                 : operands
//   sub                  : 0 = a + b + cin, 1 = a - b - cin
//   cin                  : carry-in (add) / borrow-in (sub)
//   out_valid / out_ready: result handshake
//   sum, cout            : result and carry-out (not-borrow when subtracting)
//   zero, neg, ovf       : result flags, present only with PADD_FLAGS_EN
//
// Latency is STAGES cycles from an accepted beat to out_valid; throughput is
// one beat per cycle.
//
// Configuration macro: PADD_FLAGS_EN (adds the registered zero/neg/ovf flags)
// ---------------------------------------------------------------------------
module pipelined_adder
  import padd_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PADD_FLAGS_EN
  output logic             zero,
  output logic             neg,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CHUNK = WIDTH / STAGES;

  logic          enable;
  padd_payload_t cap;
  padd_payload_t st_in [STAGES];
  padd_payload_t st_q  [STAGES];
`ifdef PADD_FLAGS_EN
  padd_payload_t st_d  [STAGES];
  padd_flags_t   flags_d;
  padd_flags_t   flags_q;
`endif

  // Every stage advances together or not at all; bubbles are carried along
  // rather than collapsed, which keeps the latency fixed.
  assign enable   = !out_valid || out_ready;
  assign in_ready = enable;

  // Input capture. Subtraction becomes a + ~b + ~cin here, so the slices
  // only ever add.
  always_comb begin
    cap                   = '0;
    cap.valid             = in_valid;
    cap.carry             = cin ^ sub;
    cap.pend_a[WIDTH-1:0] = a;
    cap.pend_b[WIDTH-1:0] = sub ? ~b : b;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign st_in[k] = cap;
    end else begin : g_chain
      assign st_in[k] = st_q[k-1];
    end

    padd_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .en_i (enable),
      .p_i  (st_in[k]),
`ifdef PADD_FLAGS_EN
      .d_o  (st_d[k]),
`endif
      .p_o  (st_q[k])
    );
  end

  assign out_valid = st_q[STAGES-1].valid;
  assign sum       = st_q[STAGES-1].done[WIDTH-1:0];
  assign cout      = st_q[STAGES-1].carry;

`ifdef PADD_FLAGS_EN
  // Flags come from the final stage's next state so they load on the same
  // edge as sum. The operand sign bits are the top bits of the last pending
  // chunk, with b already inverted for subtraction.
  always_comb begin
    flags_d      = '0;
    flags_d.zero = (st_d[STAGES-1].done[WIDTH-1:0] == '0);
    flags_d.neg  = st_d[STAGES-1].done[WIDTH-1];
    flags_d.ovf  = (st_in[STAGES-1].pend_a[CHUNK-1] == st_in[STAGES-1].pend_b[CHUNK-1])
                && (flags_d.neg != st_in[STAGES-1].pend_a[CHUNK-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (enable) begin
      flags_q <= flags_d;
    end
  end

  assign zero = flags_q.zero;
  assign neg  = flags_q.neg;
  assign ovf  = flags_q.ovf;
`endif

endmodule : pipelined_adder

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder -- directed bench for pipelined_adder.
// Drives a 4-stage instance (dut) and a 1-stage instance (dut1) from the same
// inputs. Flag outputs are checked only when PADD_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        cin;
  logic        out_ready;

  logic        in_ready,  out_valid,  cout;
  logic [31:0] sum;
  logic        in_ready1, out_valid1, cout1;
  logic [31:0] sum1;
`ifdef PADD_FLAGS_EN
  logic        zero,  neg,  ovf;
  logic        zero1, neg1, ovf1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PADD_FLAGS_EN
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
`endif
    .sum       (sum),
    .cout      (cout)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid1),
    .out_ready (out_ready),
`ifdef PADD_FLAGS_EN
    .zero      (zero1),
    .neg       (neg1),
    .ovf       (ovf1),
`endif
    .sum       (sum1),
    .cout      (cout1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one beat into an idle pipeline with out_ready=1, wait (bounded) for
  // the result on the 4-stage instance, check latency and value, then let it
  // retire.
  task automatic single(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, input logic tc,
                        input logic [31:0] es, input logic ec);
    int lat;
    lat      = 0;
    a        = ta;
    b        = tb_v;
    sub      = ts;
    cin      = tc;
    in_valid = 1'b1;
    do begin
      tick();
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    check({tag, " latency"}, 64'(lat), 64'd4);
    check({tag, " sum"},     sum,      es);
    check({tag, " cout"},    cout,     ec);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int stale;
    logic acc;

    // Reset state
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("reset out_valid", out_valid, 0);
    check("reset sum",       sum,       0);
    check("reset cout",      cout,      0);
    check("reset out_valid1", out_valid1, 0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", in_ready, 1);

    // 1: carry crosses chunk boundaries
    single("add ffff+1", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0);

    // 2: subtraction with and without borrow
    single("sub 5-7", 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);
    single("sub 7-5", 32'd7, 32'd5, 1'b1, 1'b0, 32'd2,         1'b1);
    single("add cin", 32'd10, 32'd20, 1'b0, 1'b1, 32'd31,      1'b0);
    single("sub bin", 32'd10, 32'd3,  1'b1, 1'b1, 32'd6,       1'b1);

    // 3: back-to-back beats
    a = 32'hFFFF_FFFF; b = 32'd1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    tick();
    a = 32'd3; b = 32'd4;
    tick();
    in_valid = 1'b0;
    sent = 0;
    while (!out_valid && sent < 20) begin
      tick();
      sent++;
    end
    check("b2b first valid", out_valid, 1);
    check("b2b first sum",   sum,  32'd0);
    check("b2b first cout",  cout, 1);
    tick();
    check("b2b second valid", out_valid, 1);
    check("b2b second sum",   sum,  32'd7);
    check("b2b second cout",  cout, 0);
    tick();
    check("b2b drained", out_valid, 0);

    // 4: stall with a full pipeline
    out_ready = 1'b0;
    sent = 0;
    for (int i = 0; i < 4; i++) begin
      a = 32'(10 * (sent + 1)); b = 32'(sent + 1); in_valid = 1'b1;
      acc = in_ready;
      tick();
      if (acc) sent++;
    end
    check("stall fill count", 64'(sent), 64'd4);
    check("stall out_valid",  out_valid, 1);
    a = 32'd50; b = 32'd5; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall in_ready",   in_ready,  0);
      check("stall valid held", out_valid, 1);
      check("stall sum held",   sum,       32'd11);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      check("drain valid", out_valid, 1);
      check("drain sum",   sum, 64'(11 * k));
      tick();
    end
    check("drain empty", out_valid, 0);

    // 5: reset mid-operation
    for (int i = 0; i < 3; i++) begin
      a = 32'(100 + i); b = 32'd0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("pre-reset out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset sum",       sum,       0);
    @(posedge clk);
    #1 rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) stale++;
    end
    check("no stale result", 64'(stale), 64'd0);
    single("post-reset 1+1", 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0);

    // 6: single-stage instance
    repeat (4) tick();
    a = 32'h7FFF_FFFF; b = 32'd1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("s1 latency valid", out_valid1, 1);
    check("s1 sum ovf case",  sum1,  32'h8000_0000);
    check("s1 cout ovf case", cout1, 0);
`ifdef PADD_FLAGS_EN
    check("s1 ovf",  ovf1,  1);
    check("s1 neg",  neg1,  1);
    check("s1 zero", zero1, 0);
`endif
    tick();
    check("s1 retired", out_valid1, 0);
    repeat (4) tick();
    a = 32'd0; b = 32'd0; sub = 1'b1; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sub = 1'b0;
    check("s1 0-0 valid", out_valid1, 1);
    check("s1 0-0 sum",   sum1,  32'd0);
    check("s1 0-0 cout",  cout1, 1);
`ifdef PADD_FLAGS_EN
    check("s1 0-0 zero", zero1, 1);
    check("s1 0-0 neg",  neg1,  0);
    check("s1 0-0 ovf",  ovf1,  0);
`endif
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipelined_adder

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the 4-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES carry-chained chunks, with one pipeline register per chunk.
- Valid/ready handshake on both input and output.
- Used in the RV32I datapath as a high-frequency ALU adder and address adder.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages and carry chunks; 1..WIDTH.
- CHUNK, WIDTH/STAGES, derived (localparam); bits added per stage.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = add, 1 = subtract
- cin  input  1  carry-in (add) / borrow-in (sub)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out (add) / not-borrow (sub)

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (clk, rst).
  - All stage valid bits clear, so out_valid=0.
  - sum=0, cout=0 and all pipeline data registers clear.
  - in_ready=1 after reset.
- Arithmetic:
  - add: {cout,sum} = a + b + cin.
  - sub: {cout,sum} = a + ~b + ~cin, i.e. a − b − cin; cout=1 means no borrow.
  - Inversion of b and cin is applied at input capture.
- Stage k (0..STAGES−1):
  - Adds chunk k of the skewed operands plus the carry registered by stage k−1 (stage 0 uses the effective cin).
  - Registers the chunk sum, the carry, the previously computed lower chunks, and the not-yet-added upper operand chunks.
  - Each stage's combinational path is a CHUNK-bit ripple only.
- Latency: exactly STAGES cycles from accepted beat (in_valid && in_ready) to out_valid, with no stalls. STAGES=1 gives a single registered ripple adder.
- Throughput: one beat per cycle.
- Flow control:
  - enable = !out_valid || out_ready; in_ready = enable.
  - When enable=0, every stage holds its register contents, so there is a global stall.
  - When enable=1, all stages advance.
  - A stage with no valid beat advances as a bubble; bubbles are not collapsed.
- Output: sum/cout are the final-stage registers, held stable while out_valid && !out_ready.
- Simultaneous events:
  - Accept and output-retire in the same cycle is legal, and throughput is sustained.
  - in_valid while in_ready=0: the beat is not taken; upstream holds it.
- Wrap-around: results are modulo 2^WIDTH; overflow appears only via cout (or flags, see below).
- Reset mid-operation flushes all in-flight beats. No partial result is ever presented.

Optional Feature:
- Macro PADD_FLAGS_EN.
- Defined:
  - Adds outputs zero (sum==0), neg (sum[WIDTH−1]) and ovf (signed overflow: operand sign bits equal after b inversion, result sign differs).
  - All three are registered in the final stage, aligned with sum, and held under stall.
  - Reset value 0.
- Undefined: the ports and their logic are absent. Latency and all other behaviour are unchanged.

Decomposition:
- Package padd_pkg holds:
  - the default WIDTH/STAGES localparams;
  - the stage-payload typedef (valid, carry, done bits, pending a/b bits);
  - the flag struct used when PADD_FLAGS_EN is defined.
- Sub-module padd_stage: one CHUNK-wide ripple slice plus its registers, with an enable input. It is instantiated STAGES times via generate.

Test Plan (WIDTH=32, STAGES=4 unless stated):
1. Reset then single add a=0x0000_FFFF, b=0x0000_0001, cin=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0x0001_0000, cout=0; carry crosses the chunk boundary.
2. Sub a=5, b=7, cin=0 → sum=0xFFFF_FFFE, cout=0; then a=7, b=5 → sum=2, cout=1.
3. Back-to-back beats: 0xFFFF_FFFF+1, then 3+4 on consecutive cycles → sum=0 with cout=1, then sum=7 with cout=0, on consecutive cycles.
4. Stall: hold out_ready=0 for 3 cycles with a valid output and the pipeline full → in_ready=0, sum/out_valid stable; release gives in-order delivery with no loss or duplication.
5. Reset asserted with 3 beats in flight → out_valid=0 immediately (async); after release no stale result appears and a new beat 1+1 returns 2.
6. STAGES=1 and PADD_FLAGS_EN: 0x7FFF_FFFF+1 → latency 1, sum=0x8000_0000, ovf=1, neg=1, zero=0; 0−0 sub → zero=1, cout=1.
